// File: rtl/raw_ctrl_pkg.sv
// Shared constants, state encoding and the window-length clamp for the raw delay-line readout.
package raw_ctrl_pkg;
  localparam int NWIRES        = 384;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_BIN = NWIRES / WORD_W;  // 24 slices per time bin
  localparam int MAX_TBINS     = 8;
  localparam int SETTLE_CYC    = 256;
  localparam logic [7:0] HDR_TAG = 8'hDA;

  typedef enum logic [2:0] {
    REALIGN = 3'd0,
    SETTLE  = 3'd1,
    IDLE    = 3'd2,
    CAPTURE = 3'd3,
    READOUT = 3'd4
  } state_t;

  // A window of 0 bins still reads one bin; anything past the buffer depth is capped.
  function automatic logic [3:0] clamp_tbins(input logic [3:0] t);
    if (t == 4'd0) return 4'd1;
    if (t > 4'(MAX_TBINS)) return 4'(MAX_TBINS);
    return t;
  endfunction
endpackage

// File: rtl/raw_bin_buf.sv
// Capture buffer: one full hit vector per time bin, read back one word-wide slice at a time.
module raw_bin_buf #(
  parameter int NWIRES    = 384,
  parameter int WORD_W    = 16,
  parameter int MAX_TBINS = 8,
  parameter int BIN_W     = $clog2(MAX_TBINS),
  parameter int SLICE_W   = 5
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [BIN_W-1:0]   wr_bin,
  input  logic [NWIRES-1:0]  wr_data,
  input  logic [BIN_W-1:0]   rd_bin,
  input  logic [SLICE_W-1:0] rd_slice,
  output logic [WORD_W-1:0]  rd_data
);
  logic [MAX_TBINS-1:0][NWIRES-1:0] mem;
  logic [NWIRES-1:0]                row;

  // Store one time bin per capture cycle; contents need no reset since every read follows a write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bin] <= wr_data;
  end

  // Slice 0 is the least significant word of the bin.
  always_comb begin
    row     = mem[rd_bin];
    rd_data = row[rd_slice*WORD_W +: WORD_W];
  end
endmodule

// File: rtl/raw_readout_ctrl.sv
// Raw hit delay-line sequencer: realign/settle the line, capture a window of bins on L1A,
// then stream a header plus the window to DAQ over valid/ready.
module raw_readout_ctrl
  import raw_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              l1a,
  input  logic              raw_en,
  input  logic [7:0]        cfg_delay,
  input  logic [3:0]        cfg_tbins,
  input  logic [NWIRES-1:0] rd_din,
  output logic              rd_we,
  output logic              rd_trig_stop,
  output logic [7:0]        rd_delay,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic [7:0]        l1a_drop_cnt
);
  state_t              state;
  logic [8:0]          settle_cnt;
  logic [3:0]          nb;
  logic [2:0]          bin;
  logic [4:0]          slice;
  logic [7:0]          widx;
  logic [7:0]          last_idx;
  logic [WORD_W-1:0]   buf_word;
  logic                accept;
  logic                hs;

  // The delay line is held in pointer reset both while in reset and during the realign cycle.
  always_comb begin
    rd_trig_stop = rst | (state == REALIGN);
    rd_we        = raw_en & ~rd_trig_stop;
    busy         = rst | (state != IDLE);
    accept       = (state == IDLE) && (cfg_delay == rd_delay) && l1a;
    hs           = dout_valid & dout_ready;
    last_idx     = 8'(32'(nb) * WORDS_PER_BIN);
  end

  raw_bin_buf #(
    .NWIRES   (NWIRES),
    .WORD_W   (WORD_W),
    .MAX_TBINS(MAX_TBINS),
    .BIN_W    (3),
    .SLICE_W  (5)
  ) u_buf (
    .clk     (clk),
    .wr_en   (state == CAPTURE),
    .wr_bin  (bin),
    .wr_data (rd_din),
    .rd_bin  (bin),
    .rd_slice(slice),
    .rd_data (buf_word)
  );

  // Main sequencer; bin/slice double as capture address and as the pointer to the next data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REALIGN;
      settle_cnt <= '0;
      nb         <= 4'd1;
      bin        <= '0;
      slice      <= '0;
      widx       <= '0;
      rd_delay   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (state)
        REALIGN: begin
          rd_delay   <= cfg_delay;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 9'd1;
          if (settle_cnt == 9'(SETTLE_CYC - 1)) state <= IDLE;
        end
        IDLE: begin
          // A pending delay change wins over a simultaneous trigger.
          if (cfg_delay != rd_delay) begin
            state <= REALIGN;
          end else if (l1a) begin
            nb    <= clamp_tbins(cfg_tbins);
            bin   <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if ({1'b0, bin} == nb - 4'd1) begin
            state      <= READOUT;
            bin        <= '0;
            slice      <= '0;
            widx       <= '0;
            dout       <= {HDR_TAG, 5'b0, 3'(nb - 4'd1)};
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
          end else begin
            bin <= bin + 3'd1;
          end
        end
        READOUT: begin
          if (hs) begin
            if (widx == last_idx) begin
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state      <= IDLE;
            end else begin
              widx      <= widx + 8'd1;
              dout      <= buf_word;
              dout_last <= (widx + 8'd1 == last_idx);
              if (slice == 5'(WORDS_PER_BIN - 1)) begin
                slice <= '0;
                bin   <= bin + 3'd1;
              end else begin
                slice <= slice + 5'd1;
              end
            end
          end
        end
        default: state <= REALIGN;
      endcase
    end
  end

  // Every trigger that does not start an event is counted, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1a_drop_cnt <= '0;
    end else if (l1a && !accept && l1a_drop_cnt != 8'hFF) begin
      l1a_drop_cnt <= l1a_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_raw_readout_ctrl.sv
// Scoreboard bench for raw_readout_ctrl: expected words are queued as each event is driven
// and compared whenever the DUT presents a valid word.
module tb_raw_readout_ctrl;
  localparam int NW = 384;

  logic          clk, rst, l1a, raw_en, dout_ready;
  logic [7:0]    cfg_delay;
  logic [3:0]    cfg_tbins;
  logic [NW-1:0] rd_din;
  logic          rd_we, rd_trig_stop, dout_valid, dout_last, busy;
  logic [7:0]    rd_delay, l1a_drop_cnt;
  logic [15:0]   dout;

  raw_readout_ctrl dut (
    .clk(clk), .rst(rst), .l1a(l1a), .raw_en(raw_en),
    .cfg_delay(cfg_delay), .cfg_tbins(cfg_tbins), .rd_din(rd_din),
    .rd_we(rd_we), .rd_trig_stop(rd_trig_stop), .rd_delay(rd_delay),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .l1a_drop_cnt(l1a_drop_cnt)
  );

  typedef struct packed { logic [15:0] d; logic l; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0, rx_cnt = 0, cyc = 0, rdy_mode = 0;
  bit sb_off = 0, busy_next = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pw(input int mode, input int t, input int w);
    if (mode == 0) return 16'h0100 + 16'(t);
    return {8'(8'h30 + t), 8'(w)};
  endfunction

  function automatic logic [NW-1:0] pat(input int mode, input int t);
    logic [NW-1:0] v;
    for (int w = 0; w < 24; w++) v[16*w +: 16] = pw(mode, t, w);
    return v;
  endfunction

  // dout_ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = stalled
  initial begin
    logic [3:0] rpat;
    rpat = 4'b1001;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = rpat[cyc % 4];
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard consumer: every valid cycle must show the queue head; pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_next) begin
        busy_next = 0;
        chk("busy_after_last", 32'(busy), 32'd0);
      end
      if (!sb_off && dout_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(dout_valid), 32'd0);
        end else begin
          chk("word", 32'(dout), 32'(q[0].d));
          chk("last", 32'(dout_last), 32'(q[0].l));
          if (dout_ready) begin
            if (q[0].l) busy_next = 1;
            e = q.pop_front();
            rx_cnt++;
          end
        end
      end
    end
  end

  // Called just after a posedge while the DUT is IDLE; returns just after entering READOUT.
  task automatic start_event(input int tb, input int mode, input bit drop_cap);
    int nb;
    exp_t e;
    nb = (tb == 0) ? 1 : (tb > 8) ? 8 : tb;
    cfg_tbins = 4'(tb);
    rx_cnt = 0;
    e.d = {8'hDA, 5'b0, 3'(nb - 1)};
    e.l = 1'b0;
    q.push_back(e);
    for (int t = 0; t < nb; t++)
      for (int w = 0; w < 24; w++) begin
        e.d = pw(mode, t, w);
        e.l = (t == nb - 1) && (w == 23);
        q.push_back(e);
      end
    l1a = 1'b1;
    tick(1);
    l1a = 1'b0;
    rd_din = pat(mode, 0);
    for (int t = 1; t < nb; t++) begin
      tick(1);
      rd_din = pat(mode, t);
      l1a = drop_cap && (t == 1);
    end
    tick(1);
    l1a = 1'b0;
    rd_din = {12{$urandom}};
  endtask

  task automatic wait_done(input string tag, input int exp_words);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 3000) chk({tag, "_timeout"}, 32'(q.size()), 32'd0);
    chk({tag, "_count"}, 32'(rx_cnt), 32'(exp_words));
    tick(1);
  endtask

  // Called in the REALIGN cycle after its negedge; measures the settle time in cycles.
  task automatic realign_wait(input string tag, input logic [7:0] exp_delay, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_delay"}, 32'(rd_delay), 32'(exp_delay));
        chk({tag, "_stop_low"}, 32'(rd_trig_stop), 32'd0);
        chk({tag, "_we"}, 32'(rd_we), 32'd1);
      end
      if (drop && n == 5) l1a = 1'b1;
      if (n == 6) l1a = 1'b0;
    end while (busy && n < 400);
    chk({tag, "_settle_len"}, 32'(n), 32'd257);
    l1a = 1'b0;
    tick(1);
  endtask

  initial begin
    int n;
    rst = 1'b1; l1a = 1'b0; raw_en = 1'b1; cfg_delay = 8'd20; cfg_tbins = 4'd2; rd_din = '0;
    #2;
    chk("rst_cycle_stop", 32'(rd_trig_stop), 32'd1);
    chk("rst_cycle_we", 32'(rd_we), 32'd0);
    tick(2);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_drop", 32'(l1a_drop_cnt), 32'd0);
    chk("rst_delay", 32'(rd_delay), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("realign_stop", 32'(rd_trig_stop), 32'd1);
    realign_wait("init", 8'd20, 1'b0);
    chk("init_drop", 32'(l1a_drop_cnt), 32'd0);

    // A: two bins, always ready, header DA01
    rdy_mode = 0;
    start_event(2, 0, 1'b0);
    wait_done("evA", 49);

    // B: same shape with stalls
    rdy_mode = 1;
    start_event(2, 1, 1'b0);
    wait_done("evB", 49);

    // C: triggers during capture and readout are dropped, data untouched
    start_event(3, 1, 1'b1);
    tick(5);
    l1a = 1'b1;
    tick(1);
    l1a = 1'b0;
    wait_done("evC", 73);
    chk("drop_cap_ro", 32'(l1a_drop_cnt), 32'd2);

    // D: delay change mid-readout is deferred to the next IDLE
    rdy_mode = 0;
    start_event(4, 1, 1'b0);
    tick(10);
    cfg_delay = 8'd40;
    @(negedge clk);
    chk("delay_deferred", 32'(rd_delay), 32'd20);
    chk("still_busy", 32'(busy), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dout_valid && dout_ready && dout_last) && n < 300);
    if (n >= 300) chk("evD_last_timeout", 32'(dout_last), 32'd1);
    tick(1);
    l1a = 1'b1;
    @(negedge clk);
    chk("idle_cycle", 32'(busy), 32'd0);
    tick(1);
    l1a = 1'b0;
    @(negedge clk);
    chk("dchg_stop", 32'(rd_trig_stop), 32'd1);
    chk("drop_idle_detect", 32'(l1a_drop_cnt), 32'd3);
    realign_wait("dchg", 8'd40, 1'b1);
    chk("drop_settle", 32'(l1a_drop_cnt), 32'd4);
    chk("evD_count", 32'(rx_cnt), 32'd97);
    chk("evD_q_empty", 32'(q.size()), 32'd0);

    // E: tbins=0 -> one bin; 300 dropped triggers while stalled saturate the counter
    rdy_mode = 2;
    start_event(0, 1, 1'b0);
    l1a = 1'b1;
    tick(300);
    l1a = 1'b0;
    chk("drop_sat", 32'(l1a_drop_cnt), 32'd255);
    rdy_mode = 0;
    wait_done("evE", 25);

    // F: tbins=15 clamps to 8 bins
    rdy_mode = 1;
    start_event(15, 1, 1'b0);
    wait_done("evF", 193);

    // G: reset at readout word 10 abandons the event
    rdy_mode = 0;
    start_event(2, 1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (rx_cnt < 10 && n < 200);
    if (n >= 200) chk("evG_timeout", 32'(rx_cnt), 32'd10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_off = 1;
    q.delete();
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(dout_valid), 32'd0);
    chk("rst_mid_stop", 32'(rd_trig_stop), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_drop", 32'(l1a_drop_cnt), 32'd0);
    realign_wait("rst", 8'd40, 1'b0);
    sb_off = 0;

    // H: normal operation after the abandoned event
    start_event(1, 0, 1'b0);
    wait_done("evH", 25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
